// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM and status signals shared between the RAM port arbiter and its clients.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 9
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0]       a_wdata;
   logic              a_ack;
   logic              a_err;
   logic [31:0]       a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [31:0]       b_wdata;
   logic              b_ack;
   logic              b_err;
   logic [31:0]       b_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic              busy;
   logic              grant;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
      output a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy, grant
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
      input  a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM: one access at a time, range check,
// read-latency wait and a one-cycle acknowledge back to the winning port.
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its access
// ISSUE | RAM enabled for exactly one cycle
// WAIT  | counting down the RAM read latency
// ACK   | one-cycle ack (and err) to the winner
module mem_port_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int MEM_AW        = 9,
   parameter int MEM_DEPTH     = 512,
   parameter int MEM_LATENCY   = 1,
   parameter int PRIORITY_MODE = 0
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t            state, state_nxt;
   logic              last_grant, last_grant_nxt;
   logic              we_q, we_nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic              a_ack_q, a_ack_nxt, b_ack_q, b_ack_nxt;
   logic              a_err_q, a_err_nxt, b_err_q, b_err_nxt;
   logic [31:0]       a_rdata_q, a_rdata_nxt, b_rdata_q, b_rdata_nxt;
   logic              mem_en_q, mem_en_nxt, mem_we_q, mem_we_nxt;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_nxt;
   logic [31:0]       mem_wdata_q, mem_wdata_nxt;
   logic              busy_q, busy_nxt;

   logic              win;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [31:0]       win_wdata;
   logic              win_bad;

   // Round-robin favours the port opposite the last grant; fixed mode always favours A.
   always_comb begin
      win = bus.b_req;
      if (bus.a_req && bus.b_req)
         win = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant;
      win_we    = win ? bus.b_we    : bus.a_we;
      win_addr  = win ? bus.b_addr  : bus.a_addr;
      win_wdata = win ? bus.b_wdata : bus.a_wdata;
      win_bad   = win_addr >= ADDR_W'(MEM_DEPTH);
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      we_nxt         = we_q;
      cnt_nxt        = cnt;
      a_ack_nxt      = 1'b0;
      b_ack_nxt      = 1'b0;
      a_err_nxt      = 1'b0;
      b_err_nxt      = 1'b0;
      a_rdata_nxt    = a_rdata_q;
      b_rdata_nxt    = b_rdata_q;
      mem_en_nxt     = 1'b0;
      mem_we_nxt     = 1'b0;
      mem_addr_nxt   = mem_addr_q;
      mem_wdata_nxt  = mem_wdata_q;
      case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               last_grant_nxt = win;
               we_nxt         = win_we;
               if (win_bad) begin
                  // Out-of-range access never reaches the RAM.
                  state_nxt = ACK;
                  if (win) begin
                     b_ack_nxt = 1'b1;
                     b_err_nxt = 1'b1;
                     if (!win_we) b_rdata_nxt = '0;
                  end else begin
                     a_ack_nxt = 1'b1;
                     a_err_nxt = 1'b1;
                     if (!win_we) a_rdata_nxt = '0;
                  end
               end else begin
                  state_nxt     = ISSUE;
                  mem_en_nxt    = 1'b1;
                  mem_we_nxt    = win_we;
                  mem_addr_nxt  = win_addr[MEM_AW-1:0];
                  mem_wdata_nxt = win_wdata;
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_nxt = ACK;
               a_ack_nxt = ~last_grant;
               b_ack_nxt = last_grant;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = 3'(MEM_LATENCY);
            end
         end
         WAIT: begin
            if (cnt == 3'd1) begin
               state_nxt = ACK;
               a_ack_nxt = ~last_grant;
               b_ack_nxt = last_grant;
               if (last_grant) b_rdata_nxt = bus.mem_rdata;
               else            a_rdata_nxt = bus.mem_rdata;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         we_q        <= 1'b0;
         cnt         <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_err_q     <= 1'b0;
         b_err_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         we_q        <= we_nxt;
         cnt         <= cnt_nxt;
         a_ack_q     <= a_ack_nxt;
         b_ack_q     <= b_ack_nxt;
         a_err_q     <= a_err_nxt;
         b_err_q     <= b_err_nxt;
         a_rdata_q   <= a_rdata_nxt;
         b_rdata_q   <= b_rdata_nxt;
         mem_en_q    <= mem_en_nxt;
         mem_we_q    <= mem_we_nxt;
         mem_addr_q  <= mem_addr_nxt;
         mem_wdata_q <= mem_wdata_nxt;
         busy_q      <= busy_nxt;
      end
   end

   assign bus.a_ack     = a_ack_q;
   assign bus.b_ack     = b_ack_q;
   assign bus.a_err     = a_err_q;
   assign bus.b_err     = b_err_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.grant     = last_grant;
endmodule
